ecc_dec_40_32: RTL and testbench
================================

# ecc_dec_40_32

Pipelined SEC-DED decoder that sits directly downstream of the SRAM read port. It takes each 40-bit codeword produced by the 32→40 encoder and recomputes the 7-bit syndrome. It corrects any single-bit error, flags double and other uncorrectable errors, and delivers 32-bit data over a valid/ready interface. It also keeps saturating corrected-error and uncorrectable-error counters for status readout.

## Interface
- CNT_W, 16, width of each error counter
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  codeword valid
- in_ready  out  1  decoder can accept a codeword this cycle
- in_code  in  40  codeword: [31:0] data, [38:32] check bits, [39] spare
- out_valid  out  1  decoded word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  32  corrected data
- out_ce  out  1  single-bit error corrected (data or check bit)
- out_ue  out  1  uncorrectable error; out_data is raw in_code[31:0]
- out_syndrome  out  7  syndrome of this word, bit i = check bit 32+i
- cnt_clr  in  1  synchronous clear of both counters
- ce_count  out  CNT_W  words delivered with out_ce=1, saturating
- ue_count  out  CNT_W  words delivered with out_ue=1, saturating

## Operation
- Check-bit data sets, identical to the encoder:
  - c0: 0,1,2,3,4,5,6,7,8,13,17,26,27,29
  - c1: 0,1,2,3,4,12,16,18,21,22,23,24,25,28
  - c2: 0,5,6,7,8,11,15,18,19,21,22,30,31
  - c3: 1,5,10,14,18,19,20,23,24,26,27,28,29,30
  - c4: 2,6,9,14,15,16,17,19,20,21,23,25,29,31
  - c5: 3,7,9,10,11,12,13,20,22,24,25,27,31
  - c6: 4,8,9,10,11,12,13,14,15,16,17,26,28,30
- Syndrome: s[i] = in_code[32+i] XOR parity of the data bits in set ci.
- Every data column has weight 3 and all columns are distinct. The syndrome is classified by weight:
  - weight 0: clean.
  - weight 1: check-bit error. Data passes unchanged and out_ce=1.
  - weight 3 equal to data column k: flip data bit k and set out_ce=1.
  - anything else (even weight, 5, 7, or an unmatched weight-3 value): out_ue=1 and data is passed raw.
- in_code[39] is ignored. It is excluded from the syndrome and never flagged.
- out_ce and out_ue are mutually exclusive.
- Counters increment on the output handshake (out_valid && out_ready) when the matching flag is set. They hold at 2^CNT_W−1.
- If cnt_clr coincides with an increment, the clear wins and the counter becomes 0.

## Timing
- Two-stage pipeline:
  - S1 registers in_code and the syndrome.
  - S2 registers the corrected data and flags.
- Latency is 2 cycles from the input handshake to out_valid.
- Throughput is one word per cycle while out_ready=1.
- Stage enables: S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || S2 loads.
- in_ready equals the S1 enable. It is combinational from out_ready, and no combinational path runs from in_valid to in_ready.
- Under backpressure, S2 holds out_data and all flags stable while out_valid && !out_ready. Nothing is dropped or duplicated.
- Reset values: out_valid=0, in_ready=1 (after the pipe empties), out_data=0, out_ce=0, out_ue=0, out_syndrome=0, ce_count=0, ue_count=0.
- Assertion of rst_n mid-stream discards both stages immediately. No partial word is emitted after release.

## Structure
- Shared package ecc_pkg holds:
  - the seven check-bit masks as 32-bit constants,
  - the derived 32-entry column table (7-bit syndromes),
  - the widths 32, 7 and 40.
- The encoder and decoder both take their masks from ecc_pkg.
- One sub-module, ecc_syndrome_40_32: purely combinational, 40-bit codeword in, 7-bit syndrome out. It is instantiated in S1 and reusable for an encoder self-check.

## Test plan
- Clean word: in_code=40'h24_FFFFFFFF → after 2 cycles out_data=32'hFFFFFFFF, syndrome 0, ce=ue=0, counters unchanged.
- Single data error: in_code=40'h00_00000001 → syndrome 7'b0000111, out_data=0, out_ce=1, ce_count=1.
- Single check-bit error: in_code=40'h08_00000000 → syndrome 7'b0001000, out_data=0, out_ce=1.
- Double error: in_code=40'h00_00000003 → syndrome 7'b0001100, out_ue=1, out_data=32'h00000003, ue_count=1.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-stream → outputs are held stable, in_ready=0 once both stages are full, and all 4 words arrive in order.
- Saturation and clear: with CNT_W=2, send 5 single-error words → ce_count=3. Then assert cnt_clr together with a 6th error word → ce_count=0. Finally, drop rst_n mid-stream → out_valid=0 immediately and both counters read 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SEC-DED (40,32) code definition used by both the encoder and the decoder.
// The check-bit masks are the single source of truth. The column table is derived
// from them so that the two views can never disagree.
package ecc_pkg;

   localparam int DATA_W = 32;
   localparam int CHK_W  = 7;
   localparam int CODE_W = 40;

   // Data bits covered by check bit i (bit k set => data bit k in set ci)
   localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
      32'h5403FF10,   // c6
      32'h8B503E88,   // c5
      32'hA2BBC244,   // c4
      32'h7D9C4422,   // c3
      32'hC06C89E1,   // c2
      32'h13E5101F,   // c1
      32'h2C0221FF    // c0
   };

   // Syndrome produced by a lone error on data bit k (the H-matrix column)
   function automatic logic [DATA_W-1:0][CHK_W-1:0] build_col_tab();
      logic [DATA_W-1:0][CHK_W-1:0] t;
      t = '0;
      for (int k = 0; k < DATA_W; k++) begin
         for (int i = 0; i < CHK_W; i++) begin
            t[k][i] = CHK_MASK[i][k];
         end
      end
      return t;
   endfunction

   localparam logic [DATA_W-1:0][CHK_W-1:0] COL_TAB = build_col_tab();

   // Classification of a syndrome
   typedef enum logic [1:0] {
      SYN_CLEAN = 2'd0,   // no error
      SYN_CHK   = 2'd1,   // single check-bit error
      SYN_DATA  = 2'd2,   // single data-bit error, correctable
      SYN_UE    = 2'd3    // uncorrectable
   } syn_class_e;

endpackage

// File: rtl/ecc_syndrome_40_32.sv
// Combinational syndrome generator for the (40,32) SEC-DED code.
// Bit 39 of the codeword is a spare and takes no part in the syndrome.
module ecc_syndrome_40_32
   import ecc_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [CHK_W-1:0]  syndrome
);

   logic unused_spare;
   assign unused_spare = code[CODE_W-1];

   // Recompute each check bit over its data set and compare with the stored bit
   always_comb begin
      syndrome = '0;
      for (int i = 0; i < CHK_W; i++) begin
         syndrome[i] = code[DATA_W+i] ^ (^(code[DATA_W-1:0] & CHK_MASK[i]));
      end
   end

endmodule

// File: rtl/ecc_dec_40_32.sv
// Two-stage pipelined SEC-DED decoder placed behind the SRAM read port.
// S1 captures the raw data and its syndrome; S2 holds the corrected word and flags.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A producer
// holding valid keeps its payload stable until the transfer. in_ready depends only
// on pipeline occupancy and out_ready, never on in_valid. out_* is held stable while
// out_valid && !out_ready.
module ecc_dec_40_32
   import ecc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ce,
   output logic              out_ue,
   output logic [CHK_W-1:0]  out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  ce_count,
   output logic [CNT_W-1:0]  ue_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [CHK_W-1:0]  s1_syn;
   logic              s2_valid;
   logic [CHK_W-1:0]  syn_now;
   logic              s1_en;
   logic              s2_en;
   logic              out_fire;

   syn_class_e        syn_class;
   logic [DATA_W-1:0] flip;
   logic [DATA_W-1:0] fix_data;

   ecc_syndrome_40_32 u_syndrome (
      .code     (in_code),
      .syndrome (syn_now)
   );

   assign s2_en     = !s2_valid || out_ready;
   assign s1_en     = !s1_valid || s2_en;
   assign in_ready  = s1_en;
   assign out_valid = s2_valid;
   assign out_fire  = s2_valid && out_ready;

   // Classify the S1 syndrome and build the corrected data word
   always_comb begin
      flip = '0;
      for (int k = 0; k < DATA_W; k++) begin
         flip[k] = (s1_syn == COL_TAB[k]);
      end
      // Columns all have weight 3, so a match implies a weight-3 syndrome
      if (s1_syn == '0)
         syn_class = SYN_CLEAN;
      else if ($countones(s1_syn) == 1)
         syn_class = SYN_CHK;
      else if (|flip)
         syn_class = SYN_DATA;
      else
         syn_class = SYN_UE;
      fix_data = (syn_class == SYN_DATA) ? (s1_data ^ flip) : s1_data;
   end

   // Stage 1: capture data and syndrome of the accepted codeword
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_code[DATA_W-1:0];
            s1_syn  <= syn_now;
         end
      end
   end

   // Stage 2: register corrected data and flags, held under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid     <= 1'b0;
         out_data     <= '0;
         out_ce       <= 1'b0;
         out_ue       <= 1'b0;
         out_syndrome <= '0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data     <= fix_data;
            out_ce       <= (syn_class == SYN_CHK) || (syn_class == SYN_DATA);
            out_ue       <= (syn_class == SYN_UE);
            out_syndrome <= s1_syn;
         end
      end
   end

   // Saturating event counters, bumped on delivery; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_count <= '0;
         ue_count <= '0;
      end else if (cnt_clr) begin
         ce_count <= '0;
         ue_count <= '0;
      end else begin
         if (out_fire && out_ce && (ce_count != CNT_MAX))
            ce_count <= ce_count + CNT_W'(1);
         if (out_fire && out_ue && (ue_count != CNT_MAX))
            ue_count <= ue_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ecc_dec_40_32.sv
// Testbench for ecc_dec_40_32: directed vector table, backpressure, counter
// saturation/clear, randomized stream against a set-list reference model, and
// mid-stream reset.
module tb_ecc_dec_40_32;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [39:0]   in_code = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_data;
   logic          out_ce;
   logic          out_ue;
   logic [6:0]    out_syndrome;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] ce_count;
   logic [CW-1:0] ue_count;

   always #5 clk = ~clk;

   ecc_dec_40_32 #(.CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_ce       (out_ce),
      .out_ue       (out_ue),
      .out_syndrome (out_syndrome),
      .cnt_clr      (cnt_clr),
      .ce_count     (ce_count),
      .ue_count     (ue_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Data-bit sets per check bit, -1 = unused slot
   int sets [7][14] = '{
      '{0,1,2,3,4,5,6,7,8,13,17,26,27,29},
      '{0,1,2,3,4,12,16,18,21,22,23,24,25,28},
      '{0,5,6,7,8,11,15,18,19,21,22,30,31,-1},
      '{1,5,10,14,18,19,20,23,24,26,27,28,29,30},
      '{2,6,9,14,15,16,17,19,20,21,23,25,29,31},
      '{3,7,9,10,11,12,13,20,22,24,25,27,31,-1},
      '{4,8,9,10,11,12,13,14,15,16,17,26,28,30}
   };

   function automatic logic [6:0] ref_syn(input logic [39:0] c);
      logic [6:0] s;
      for (int i = 0; i < 7; i++) begin
         s[i] = c[32+i];
         for (int j = 0; j < 14; j++)
            if (sets[i][j] >= 0) s[i] = s[i] ^ c[sets[i][j]];
      end
      return s;
   endfunction

   function automatic logic [39:0] ref_encode(input logic [31:0] d);
      logic [39:0] c;
      c = {8'h00, d};
      c[38:32] = ref_syn(c);
      return c;
   endfunction

   // Packed expectation: {ue, ce, syndrome[6:0], data[31:0]}
   function automatic logic [40:0] ref_decode(input logic [39:0] c);
      logic [6:0]  s;
      logic [31:0] d;
      logic [39:0] one_hot;
      logic        ce;
      logic        ue;
      int          w;
      s  = ref_syn(c);
      d  = c[31:0];
      ce = 1'b0;
      ue = 1'b0;
      w  = $countones(s);
      if (w == 1) ce = 1'b1;
      else if (w != 0) begin
         ue = 1'b1;
         for (int k = 0; k < 32; k++) begin
            one_hot = '0;
            one_hot[k] = 1'b1;
            if (ref_syn(one_hot) == s) begin
               d[k] = ~d[k];
               ce = 1'b1;
               ue = 1'b0;
            end
         end
      end
      return {ue, ce, s, d};
   endfunction

   // ---------------- scoreboard ----------------
   logic [40:0] exp_q[$];
   logic        mon_on = 1'b0;
   int          m_ce = 0;
   int          m_ue = 0;
   logic [40:0] mon_e;
   logic        mon_fire;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_ce = 0;
         m_ue = 0;
      end else if (mon_on) begin
         check("ce_count", 64'(ce_count), 64'(m_ce));
         check("ue_count", 64'(ue_count), 64'(m_ue));
         mon_fire = 1'b0;
         mon_e    = '0;
         if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'd0);
            else begin
               mon_e = exp_q[0];
               check("out_data", 64'(out_data), 64'(mon_e[31:0]));
               check("out_syndrome", 64'(out_syndrome), 64'(mon_e[38:32]));
               check("out_ce", 64'(out_ce), 64'(mon_e[39]));
               check("out_ue", 64'(out_ue), 64'(mon_e[40]));
               if (out_ready) begin
                  mon_fire = 1'b1;
                  void'(exp_q.pop_front());
               end
            end
         end
         if (cnt_clr) begin
            m_ce = 0;
            m_ue = 0;
         end else if (mon_fire) begin
            if (mon_e[39] && m_ce < CMAX) m_ce++;
            if (mon_e[40] && m_ue < CMAX) m_ue++;
         end
         if (in_valid && in_ready) exp_q.push_back(ref_decode(in_code));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_one(input logic [39:0] c);
      int t;
      in_valid = 1'b1;
      in_code  = c;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   logic [39:0] drv_q[$];
   logic        drv_done;

   task automatic drive_list(input int max_gap);
      int g;
      while (drv_q.size() > 0) begin
         g = $urandom_range(0, max_gap);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         send_one(drv_q.pop_front());
      end
      drv_done = 1'b1;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [39:0] rand_word(input int nerr);
      logic [39:0] c;
      int          used [$];
      int          p;
      c = ref_encode($urandom());
      c[39] = 1'($urandom_range(0, 1));
      for (int e = 0; e < nerr; e++) begin
         do p = $urandom_range(0, 38); while (p inside {used});
         used.push_back(p);
         c[p] = ~c[p];
      end
      return c;
   endfunction

   function automatic logic [39:0] single_data_err();
      logic [39:0] c;
      c = ref_encode($urandom());
      c[$urandom_range(0, 31)] ^= 1'b1;
      return c;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [39:0] code;
      logic [31:0] data;
      logic [6:0]  syn;
      logic        ce;
      logic        ue;
      int          cec;
      int          uec;
   } vec_t;

   vec_t vt [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{40'h24FFFFFFFF, 32'hFFFFFFFF, 7'h00, 1'b0, 1'b0, 0, 0};
      vt[1] = '{40'h0000000001, 32'h00000000, 7'h07, 1'b1, 1'b0, 1, 0};
      vt[2] = '{40'h0800000000, 32'h00000000, 7'h08, 1'b1, 1'b0, 2, 0};
      vt[3] = '{40'h0000000003, 32'h00000003, 7'h0C, 1'b0, 1'b1, 2, 1};
      vt[4] = '{40'hA4FFFFFFFF, 32'hFFFFFFFF, 7'h00, 1'b0, 1'b0, 2, 1};
      vt[5] = '{40'h0300000000, 32'h00000000, 7'h03, 1'b0, 1'b1, 2, 2};
      vt[6] = '{40'h8000000001, 32'h00000000, 7'h07, 1'b1, 1'b0, 3, 2};
      vt[7] = '{40'h7F00000000, 32'h00000000, 7'h7F, 1'b0, 1'b1, 3, 3};
      vt[8] = '{40'h0080000000, 32'h00000000, 7'h34, 1'b1, 1'b0, 3, 3};
      vt[9] = '{40'h0000000003, 32'h00000003, 7'h0C, 1'b0, 1'b1, 3, 3};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_flags", 64'({out_ce, out_ue}), 64'd0);
      check("rst_syndrome", 64'(out_syndrome), 64'd0);
      check("rst_counts", 64'({ce_count, ue_count}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: one word at a time through an empty pipe
      for (int v = 0; v < 10; v++) begin
         send_one(vt[v].code);
         @(negedge clk);
         check($sformatf("v%0d_lat_valid0", v), 64'(out_valid), 64'd0);
         @(negedge clk);
         check($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'd1);
         check($sformatf("v%0d_out_data", v), 64'(out_data), 64'(vt[v].data));
         check($sformatf("v%0d_syndrome", v), 64'(out_syndrome), 64'(vt[v].syn));
         check($sformatf("v%0d_ce", v), 64'(out_ce), 64'(vt[v].ce));
         check($sformatf("v%0d_ue", v), 64'(out_ue), 64'(vt[v].ue));
         @(negedge clk);
         check($sformatf("v%0d_ce_count", v), 64'(ce_count), 64'(vt[v].cec));
         check($sformatf("v%0d_ue_count", v), 64'(ue_count), 64'(vt[v].uec));
         check($sformatf("v%0d_empty", v), 64'(out_valid), 64'd0);
         @(posedge clk);
         #1;
      end

      // Clear counters, then hand checking over to the scoreboard
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      check("clr_counts", 64'({ce_count, ue_count}), 64'd0);
      exp_q.delete();
      m_ce = 0;
      m_ue = 0;
      mon_on = 1'b1;

      // Backpressure: 4 words, out_ready low for 3 cycles once the pipe fills
      out_ready = 1'b0;
      drv_done  = 1'b0;
      for (int i = 0; i < 4; i++) drv_q.push_back(rand_word(i % 3));
      fork
         drive_list(0);
         begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("bp_in_ready_low", 64'(in_ready), 64'd0);
               check("bp_out_valid", 64'(out_valid), 64'd1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Saturation: 5 single-error words with a 2-bit counter
      drv_done = 1'b0;
      for (int i = 0; i < 5; i++) drv_q.push_back(single_data_err());
      drive_list(0);
      wait_drain();
      check("ce_saturated", 64'(ce_count), 64'(CMAX));

      // Clear coinciding with a 6th corrected word: clear wins
      send_one(single_data_err());
      @(posedge clk);
      #1;
      check("clr_coincide_valid", 64'(out_valid), 64'd1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      check("ce_clr_wins", 64'(ce_count), 64'd0);
      wait_drain();

      // Randomized stream with random backpressure, gaps and clears
      drv_done = 1'b0;
      for (int i = 0; i < 300; i++) drv_q.push_back(rand_word($urandom_range(0, 3)));
      fork
         drive_list(1);
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
               cnt_clr   = ($urandom_range(0, 15) == 0);
            end
         end
      join
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      wait_drain();

      // Mid-stream reset: pipe full, then rst_n drops
      mon_on = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_code  = single_data_err();
         @(posedge clk);
         #1;
      end
      check("pre_rst_out_valid", 64'(out_valid), 64'd1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ce_count", 64'(ce_count), 64'd0);
      check("mid_rst_ue_count", 64'(ue_count), 64'd0);
      check("mid_rst_out_data", 64'(out_data), 64'd0);
      check("mid_rst_flags", 64'({out_ce, out_ue}), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_output", 64'(out_valid), 64'd0);
      end
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
